// File: rtl/dmem_responder.sv
// dmem_responder: d_mem_* bus slave serving a RAM window plus a GPIO/timer/TX-FIFO MMIO page
module dmem_responder #(
  parameter int RAM_DEPTH  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [11:0] d_mem_addr,
  input  logic [7:0]  d_mem_data_out,
  output logic [7:0]  d_mem_data_in,
  input  logic        d_mem_en,
  input  logic        d_mem_rd,
  input  logic        d_mem_wr,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [7:0]    r_ram [RAM_DEPTH];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic [15:0]   r_timer;
  logic [7:0]    r_hi_latch, r_sync1, r_sync2, r_gpio_out;
  logic          w_rd_acc, w_wr_acc, w_is_ram, w_push, w_push_ok, w_pop, w_full, w_empty;
  logic [7:0]    w_rdata;
  assign w_rd_acc  = d_mem_en & d_mem_rd;
  assign w_wr_acc  = d_mem_en & d_mem_wr;
  assign w_is_ram  = d_mem_addr < 12'(RAM_DEPTH);
  assign w_full    = r_count == (PW+1)'(FIFO_DEPTH);
  assign w_empty   = r_count == '0;
  assign w_push    = w_wr_acc & (d_mem_addr == 12'hFF4);
  assign w_push_ok = w_push & ~w_full;
  assign w_pop     = tx_valid & tx_ready;
  assign tx_valid  = ~w_empty;
  assign tx_data   = tx_valid ? r_fifo[r_rd_ptr] : 8'h00;
  assign gpio_out  = r_gpio_out;
  assign d_mem_data_in = w_rd_acc ? w_rdata : 8'h00;
  always_comb begin
    w_rdata = 8'h00;
    if (w_is_ram)
      w_rdata = r_ram[d_mem_addr[AW-1:0]];
    else
      case (d_mem_addr)
        12'hFF0: w_rdata = r_gpio_out;
        12'hFF1: w_rdata = r_sync2;
        12'hFF2: w_rdata = r_timer[7:0];
        12'hFF3: w_rdata = r_hi_latch;
        12'hFF5: w_rdata = {5'b0, r_ovf, w_empty, w_full};
        default: w_rdata = 8'h00;
      endcase
  end
  // RAM shares the async-reset process but is left out of the reset branch so its contents survive reset
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_timer    <= '0;
      r_hi_latch <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_wr_acc && w_is_ram) r_ram[d_mem_addr[AW-1:0]] <= d_mem_data_out;
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_wr_acc && d_mem_addr == 12'hFF0) r_gpio_out <= d_mem_data_out;
      // the clearing edge counts as tick 0, so the next cycle already reads 1
      r_timer <= (w_wr_acc && d_mem_addr == 12'hFF2) ? 16'd1 : r_timer + 16'd1;
      if (w_rd_acc && d_mem_addr == 12'hFF2) r_hi_latch <= r_timer[15:8];
      if (w_push_ok) begin
        r_fifo[r_wr_ptr] <= d_mem_data_out;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
      r_ovf <= (w_push & w_full) | (r_ovf & ~(w_rd_acc & (d_mem_addr == 12'hFF5)));
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table plus directed sequences; TX bytes scoreboarded through a queue
module tb_dmem_responder;
  logic        clk = 1'b0, reset_ = 1'b0;
  logic [11:0] d_mem_addr = '0;
  logic [7:0]  d_mem_data_out = '0, d_mem_data_in, gpio_in = '0, gpio_out, tx_data;
  logic        d_mem_en = 1'b0, d_mem_rd = 1'b0, d_mem_wr = 1'b0, tx_valid, tx_ready = 1'b0;
  int n_cmp = 0, n_err = 0, mcount = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  typedef struct {
    logic en, rd, wr;
    logic [11:0] addr;
    logic [7:0] wd;
    logic chk;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[20];

  dmem_responder dut (
    .clk(clk), .reset_(reset_), .d_mem_addr(d_mem_addr), .d_mem_data_out(d_mem_data_out),
    .d_mem_data_in(d_mem_data_in), .d_mem_en(d_mem_en), .d_mem_rd(d_mem_rd), .d_mem_wr(d_mem_wr),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // one bus cycle: drive at negedge, leave 2 time units for combinational settling
  task automatic drive(input logic en, input logic rd, input logic wr, input logic [11:0] addr,
                       input logic [7:0] wd, input logic rdy);
    @(negedge clk);
    d_mem_en = en; d_mem_rd = rd; d_mem_wr = wr; d_mem_addr = addr; d_mem_data_out = wd; tx_ready = rdy;
    if (en && wr && addr == 12'hFF4 && mcount < 4) begin
      tx_q.push_back(wd);
      mcount++;
    end
    #2;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] addr, input logic [7:0] exp, input logic rdy);
    drive(1'b1, 1'b1, 1'b0, addr, 8'h00, rdy);
    chk(name, d_mem_data_in, exp);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && tx_q.size() != 0; k++) drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    chk(name, 8'(tx_q.size()), 8'h00);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    chk({name, "_valid"}, {7'b0, tx_valid}, 8'h00);
  endtask

  always @(negedge clk) begin
    #3;
    if (reset_ && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL tx_pop: got %02h expected no byte", tx_data);
      end else begin
        chk("tx_data", tx_data, tx_q.pop_front());
        mcount--;
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 12'h005, 8'h3A, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 12'h005, 8'h00, 1'b1, 8'h3A};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 12'hFF7, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 12'h3FF, 8'h5C, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 12'h3FF, 8'h00, 1'b1, 8'h5C};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 12'h400, 8'h00, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 12'hFF4, 8'h11, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 12'hFF4, 8'h22, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 12'hFF4, 8'h33, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 12'hFF4, 8'h44, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 12'hFF5, 8'h00, 1'b1, 8'h01};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 12'hFF4, 8'h55, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 12'hFF5, 8'h00, 1'b1, 8'h05};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 12'hFF5, 8'h00, 1'b1, 8'h01};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 12'hFF4, 8'h00, 1'b1, 8'h00};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 12'hFF0, 8'h99, 1'b1, 8'h00};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b1, 8'h99};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 12'hFF0, 8'hC3, 1'b0, 8'h00};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b1, 8'hC3};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 12'hFF0, 8'h00, 1'b1, 8'h00};
    // reset asserted before any clock edge
    #1;
    d_mem_en = 1'b1; d_mem_rd = 1'b1; d_mem_addr = 12'hFF5;
    #1;
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_status", d_mem_data_in, 8'h02);
    d_mem_en = 1'b0;
    #1;
    chk("rst_rdata", d_mem_data_in, 8'h00);
    @(negedge clk);
    reset_ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].en, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, 1'b0);
      if (vecs[i].chk) begin
        rd_q.push_back(vecs[i].exp);
        chk($sformatf("vec%0d", i), d_mem_data_in, rd_q.pop_front());
      end
    end
    chk("gpio_out_c3", gpio_out, 8'hC3);
    drive(1'b1, 1'b0, 1'b1, 12'hFF0, 8'h3C, 1'b0);
    chk("gpio_out_pre_edge", gpio_out, 8'hC3);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    chk("gpio_out_3c", gpio_out, 8'h3C);
    drain("drain1");
    rd_chk("status_empty", 12'hFF5, 8'h02, 1'b0);
    // overflow with a simultaneous pop, then accepted push+pop
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'h66, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'h77, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'h88, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'h99, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'hAA, 1'b1);
    rd_chk("status_ovf_pop", 12'hFF5, 8'h04, 1'b0);
    rd_chk("status_ovf_clr", 12'hFF5, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'hBB, 1'b1);
    rd_chk("status_pushpop", 12'hFF5, 8'h00, 1'b0);
    drain("drain2");
    // timer
    drive(1'b1, 1'b0, 1'b1, 12'hFF2, 8'h5A, 1'b0);
    rd_chk("timer_w1", 12'hFF2, 8'h01, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    rd_chk("timer_w3", 12'hFF2, 8'h03, 1'b0);
    rd_chk("timer_hi_0", 12'hFF3, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF2, 8'h00, 1'b0);
    for (int k = 0; k < 509; k++) drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    rd_chk("timer_lo_fe", 12'hFF2, 8'hFE, 1'b0);
    rd_chk("timer_hi_01", 12'hFF3, 8'h01, 1'b0);
    // GPIO input synchroniser
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    gpio_in = 8'hA5;
    rd_chk("gpio_in_1edge", 12'hFF1, 8'h00, 1'b0);
    rd_chk("gpio_in_2edge", 12'hFF1, 8'hA5, 1'b0);
    // reset mid-operation: FIFO emptied, in-flight RAM write aborted
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'h01, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 12'hFF4, 8'h02, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    chk("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
    reset_ = 1'b0;
    tx_q.delete();
    mcount = 0;
    #1;
    chk("mid_rst_valid", {7'b0, tx_valid}, 8'h00);
    chk("mid_rst_gpio_out", gpio_out, 8'h00);
    d_mem_en = 1'b1; d_mem_rd = 1'b1; d_mem_addr = 12'hFF5;
    #1;
    chk("mid_rst_status", d_mem_data_in, 8'h02);
    d_mem_rd = 1'b0; d_mem_wr = 1'b1; d_mem_addr = 12'h005; d_mem_data_out = 8'hEE;
    @(posedge clk);
    #1;
    d_mem_en = 1'b0; d_mem_wr = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    rd_chk("ram_kept", 12'h005, 8'h3A, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    chk("post_rst_tx_q", 8'(tx_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
